i2c_reg_target: RTL and testbench

- Parametrised, system-clock-oversampled I2C target with a general-purpose register file. Successor to the SCL-clocked, write-only, fixed-address, single-byte receiver.
- Adds:
  - parametrised device address and register count
  - multi-byte writes with auto-increment
  - read transfers, including repeated START
  - a write strobe
- Sits between the chip's I2C pins (open-drain, via the top-level pad logic) and the configuration registers consumed by the datapath.

---
 rtl/i2c_reg_target.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_i2c_reg_target.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_target.sv
// -----------------------------------------------------------------------------
// i2c_reg_target
//   I2C target with a small general-purpose register file. The system clock
//   oversamples SCL/SDA (clk must be at least 16x the SCL frequency). Writes
//   auto-increment through the registers. Reads are supported, including after
//   a repeated START. Every register write raises a one-clock strobe.
//
//   Write transfer: START, {I2C_ADDR,0}, register index, data bytes..., STOP
//   Read transfer : START, {I2C_ADDR,1}, data bytes from the pointer...
//
// Ports
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   scl_in    raw SCL pad input
//   sda_in    raw SDA pad input (the wired-AND bus value)
//   sda_oe    1 = pull SDA low; SDA is never driven high
//   reg_data  flat register file, reg k = bits [8k+7:8k]
//   wr_pulse  one-clock strobe per register write
//   wr_index  index of the register written, valid with wr_pulse
//   busy      high from START until STOP or an abort to IDLE
// -----------------------------------------------------------------------------
module i2c_reg_target #(
  parameter logic [6:0] I2C_ADDR    = 7'h47,
  parameter int         NUM_REGS    = 11,
  parameter int         REG_AW      = 4,
  parameter int         SYNC_STAGES = 2,
  parameter int         READ_EN     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  sda_oe,
  output logic [NUM_REGS*8-1:0] reg_data,
  output logic                  wr_pulse,
  output logic [REG_AW-1:0]     wr_index,
  output logic                  busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_REG, S_REG_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK
  } state_e;

  // ---------------------------------------------------------------------------
  // Input conditioning: synchroniser chain plus one history flop per line.
  // Everything resets to 1, the idle bus level, so leaving reset never looks
  // like an edge.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_hist_q, sda_hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop take its old input
      // value at the edge. Blocking assignments here would collapse the
      // synchroniser chain into a single stage.
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_hist_q <= scl_sync_q[SYNC_STAGES-1];
      sda_hist_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  logic scl_s, sda_s, scl_rise, scl_fall, sda_rise, sda_fall, start_cond, stop_cond;
  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise   =  scl_s & ~scl_hist_q;
  assign scl_fall   = ~scl_s &  scl_hist_q;
  assign sda_rise   =  sda_s & ~sda_hist_q;
  assign sda_fall   = ~sda_s &  sda_hist_q;
  // SDA may only move while SCL is low. An SDA edge with SCL high is therefore
  // a bus condition, never a data bit.
  assign start_cond = sda_fall & scl_s;
  assign stop_cond  = sda_rise & scl_s;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic              full_q, full_d;     // 8 bits received, waiting for the SCL fall
  logic [7:0]        shift_q, shift_d;
  logic [REG_AW-1:0] ptr_q, ptr_d;
  logic              rd_q, rd_d;         // R/W bit of the accepted address
  logic              mack_q, mack_d;     // master ACK bit sampled on the 9th rise
  logic              sda_oe_q, sda_oe_d;
  logic              busy_q, busy_d;
  logic              wr_pulse_q, wr_pulse_d;
  logic [REG_AW-1:0] wr_index_q, wr_index_d;
  logic              wr_en;
  logic [7:0]        regs_q [NUM_REGS];

  logic              byte_done, receiving, addr_ok;
  logic [REG_AW-1:0] ptr_inc;
  logic [7:0]        rd_byte;

  assign receiving = (state_q == S_ADDR) || (state_q == S_REG) || (state_q == S_WDATA);
  assign byte_done = scl_fall & full_q;
  assign ptr_inc   = (ptr_q == REG_AW'(NUM_REGS - 1)) ? '0 : ptr_q + REG_AW'(1);
  assign rd_byte   = regs_q[ptr_q];
  assign addr_ok   = (shift_q[7:1] == I2C_ADDR) && (!shift_q[0] || (READ_EN != 0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      full_q     <= 1'b0;
      shift_q    <= '0;
      ptr_q      <= '0;
      rd_q       <= 1'b0;
      mack_q     <= 1'b1;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_pulse_q <= 1'b0;
      wr_index_q <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      full_q     <= full_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      rd_q       <= rd_d;
      mack_q     <= mack_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_pulse_q <= wr_pulse_d;
      wr_index_q <= wr_index_d;
    end
  end

  // The register file is configuration state read directly by the datapath,
  // so it must come out of reset at a known value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this array is reset because its contents are architecturally
      // visible after reset. Leave pure storage RAMs unreset so they can map
      // onto memory macros.
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
    end else if (wr_en) begin
      regs_q[ptr_q] <= shift_q;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first. Any path that
    // leaves one unassigned would infer a latch.
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    full_d     = full_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    rd_d       = rd_q;
    mack_d     = mack_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_pulse_d = 1'b0;
    wr_index_d = wr_index_q;

    // A completed data byte commits even if a bus condition lands in the same
    // clock. That is why this sits outside the START/STOP priority below.
    wr_en = (state_q == S_WDATA) && byte_done;
    if (wr_en) begin
      wr_pulse_d = 1'b1;
      wr_index_d = ptr_q;
      ptr_d      = ptr_inc;
    end

    if (start_cond) begin
      state_d   = S_ADDR;
      bit_cnt_d = '0;
      full_d    = 1'b0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b1;
    end else if (stop_cond) begin
      state_d   = S_IDLE;
      bit_cnt_d = '0;
      full_d    = 1'b0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      // Shift in MSB first. The 3-bit counter wraps to 0 on the 8th bit, and
      // full_q then holds the byte until the SCL fall that ends that bit.
      if (receiving && scl_rise && !full_q) begin
        shift_d   = {shift_q[6:0], sda_s};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) full_d = 1'b1;
      end

      case (state_q)
        S_ADDR: if (byte_done) begin
          full_d = 1'b0;
          if (addr_ok) begin
            sda_oe_d = 1'b1;
            rd_d     = shift_q[0];
            state_d  = S_ADDR_ACK;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end
        S_ADDR_ACK: if (scl_fall) begin
          if (rd_q) begin
            shift_d   = rd_byte;
            sda_oe_d  = ~rd_byte[7];
            bit_cnt_d = '0;
            state_d   = S_RDATA;
          end else begin
            sda_oe_d = 1'b0;
            state_d  = S_REG;
          end
        end
        S_REG: if (byte_done) begin
          full_d = 1'b0;
          if ({1'b0, shift_q} < 9'(NUM_REGS)) begin
            ptr_d    = shift_q[REG_AW-1:0];
            sda_oe_d = 1'b1;
            state_d  = S_REG_ACK;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end
        S_REG_ACK: if (scl_fall) begin
          sda_oe_d = 1'b0;
          state_d  = S_WDATA;
        end
        S_WDATA: if (byte_done) begin
          full_d   = 1'b0;
          sda_oe_d = 1'b1;
          state_d  = S_WDATA_ACK;
        end
        S_WDATA_ACK: if (scl_fall) begin
          sda_oe_d = 1'b0;
          state_d  = S_WDATA;
        end
        // bit_cnt_q counts the bits already on the bus. The fall after the
        // 8th bit releases SDA so the master can drive its ACK.
        S_RDATA: if (scl_fall) begin
          if (bit_cnt_q == 3'd7) begin
            sda_oe_d = 1'b0;
            ptr_d    = ptr_inc;
            state_d  = S_RDATA_ACK;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {shift_q[6:0], 1'b0};
            sda_oe_d  = ~shift_q[6];
          end
        end
        S_RDATA_ACK: begin
          if (scl_rise) begin
            mack_d = sda_s;
          end else if (scl_fall) begin
            if (!mack_q) begin
              shift_d   = rd_byte;
              sda_oe_d  = ~rd_byte[7];
              bit_cnt_d = '0;
              state_d   = S_RDATA;
            end else begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
    assign reg_data[8*k +: 8] = regs_q[k];
  end

  assign sda_oe   = sda_oe_q;
  assign busy     = busy_q;
  assign wr_pulse = wr_pulse_q;
  assign wr_index = wr_index_q;

endmodule

// File: tb/tb_i2c_reg_target.sv
// -----------------------------------------------------------------------------
// tb_i2c_reg_target
//   Self-checking bench for i2c_reg_target. A bit-level I2C master drives SCL
//   and SDA. Two targets sit on separate open-drain SDA lines: the main one
//   (READ_EN=1) and a second one built with READ_EN=0. Expected results come
//   from a hand-written vector table, a few directed sequences, and a
//   transaction-level model of the register file and its pointer.
// -----------------------------------------------------------------------------
module tb_i2c_reg_target;
  localparam int NR = 11;
  localparam int Q  = 6;   // clk cycles per quarter SCL period

  logic             clk = 1'b0;
  logic             rst_n;
  logic             scl, sda_m;
  logic             sda_line, sda_line_nr;
  logic             sda_oe, wr_pulse, busy;
  logic [NR*8-1:0]  reg_data;
  logic [3:0]       wr_index;
  logic             sda_oe_nr, wr_pulse_nr, busy_nr;
  logic [NR*8-1:0]  reg_data_nr;
  logic [3:0]       wr_index_nr;

  assign sda_line    = sda_m & ~sda_oe;
  assign sda_line_nr = sda_m & ~sda_oe_nr;

  i2c_reg_target #(.I2C_ADDR(7'h47), .NUM_REGS(NR), .REG_AW(4), .SYNC_STAGES(2), .READ_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .scl_in(scl), .sda_in(sda_line), .sda_oe(sda_oe),
    .reg_data(reg_data), .wr_pulse(wr_pulse), .wr_index(wr_index), .busy(busy));

  i2c_reg_target #(.I2C_ADDR(7'h47), .NUM_REGS(NR), .REG_AW(4), .SYNC_STAGES(2), .READ_EN(0)) dut_nr (
    .clk(clk), .rst_n(rst_n), .scl_in(scl), .sda_in(sda_line_nr), .sda_oe(sda_oe_nr),
    .reg_data(reg_data_nr), .wr_pulse(wr_pulse_nr), .wr_index(wr_index_nr), .busy(busy_nr));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Observed write strobes
  logic [3:0] wr_seen[$];
  always @(negedge clk) if (rst_n && wr_pulse) wr_seen.push_back(wr_index);

  // Reference model: register contents, pointer, expected write indices
  logic [7:0] m_regs[NR];
  int         m_ptr;
  int         exp_wr[$];

  task automatic model_reset();
    for (int k = 0; k < NR; k++) m_regs[k] = 8'h00;
    m_ptr = 0;
    exp_wr.delete();
    wr_seen.delete();
  endtask

  // Expected ACK pattern: bit0 = address, bit1 = register index, bit 2+i = data i
  task automatic model_write(input logic [7:0] addr, input logic [7:0] regb, input int n,
                             input logic [2:0][7:0] d, output logic [4:0] acks);
    acks = '0;
    if (addr == 8'h8E) begin
      acks[0] = 1'b1;
      if (regb < NR) begin
        acks[1] = 1'b1;
        m_ptr = regb;
        for (int i = 0; i < n; i++) begin
          acks[2+i] = 1'b1;
          m_regs[m_ptr] = d[i];
          exp_wr.push_back(m_ptr);
          m_ptr = (m_ptr + 1) % NR;
        end
      end
    end
  endtask

  // ---------------- bit-level master ----------------
  task automatic qwait();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    if (scl == 1'b0) begin
      sda_m = 1'b1; qwait();
      scl = 1'b1;   qwait();
    end
    sda_m = 1'b0; qwait();
    scl = 1'b0;   qwait();
  endtask

  task automatic bus_stop(input bit chk_busy);
    sda_m = 1'b0; qwait();
    scl = 1'b1;   qwait();
    if (chk_busy) check("busy_before_stop", busy, 1);
    sda_m = 1'b1;
    repeat (3) @(negedge clk);
    if (chk_busy) check("busy_3clk_after_stop", busy, 0);
    qwait();
  endtask

  task automatic clk_bit(input logic b, output logic r, output logic r_nr);
    sda_m = b;  qwait();
    scl = 1'b1; qwait();
    r = sda_line; r_nr = sda_line_nr;
    qwait();
    scl = 1'b0; qwait();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack, output logic ack_nr);
    logic r, rn;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], r, rn);
    clk_bit(1'b1, r, rn);
    ack = ~r; ack_nr = ~rn;
  endtask

  task automatic recv_byte(input logic m_ack, output logic [7:0] b);
    logic r, rn;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, r, rn);
      b[i] = r;
    end
    clk_bit(~m_ack, r, rn);
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [7:0] regb, input int n,
                          input logic [2:0][7:0] d, input bit chk_busy, output logic [4:0] acks);
    logic a, an;
    acks = '0;
    bus_start();
    send_byte(addr, a, an); acks[0] = a;
    send_byte(regb, a, an); acks[1] = a;
    for (int i = 0; i < n; i++) begin
      send_byte(d[i], a, an); acks[2+i] = a;
    end
    bus_stop(chk_busy);
  endtask

  task automatic check_wr(input string tag, input int exp_n);
    check({tag, "_wr_count"}, wr_seen.size(), exp_n);
    for (int k = 0; k < exp_wr.size() && k < wr_seen.size(); k++)
      check($sformatf("%s_wr_index%0d", tag, k), wr_seen[k], exp_wr[k]);
    wr_seen.delete();
    exp_wr.delete();
  endtask

  task automatic check_regs(input string tag);
    for (int k = 0; k < NR; k++)
      check($sformatf("%s_reg%0d", tag, k), reg_data[8*k +: 8], m_regs[k]);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]      addr;
    logic [7:0]      regb;
    int              n;
    logic [2:0][7:0] d;        // d[0] is sent first
    logic [4:0]      exp_ack;
    int              exp_wr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [4:0] acks, macks, mask;
    logic [7:0] b;
    logic       a, an;
    int         n;

    vecs[0] = '{8'h8E, 8'h03, 1, {8'h00, 8'h00, 8'hA5}, 5'b00111, 1};
    vecs[1] = '{8'h8E, 8'h09, 3, {8'h33, 8'h22, 8'h11}, 5'b11111, 3};  // wraps 10 -> 0
    vecs[2] = '{8'h90, 8'h03, 1, {8'h00, 8'h00, 8'h77}, 5'b00000, 0};  // wrong address
    vecs[3] = '{8'h8E, 8'h0C, 1, {8'h00, 8'h00, 8'h55}, 5'b00001, 0};  // index out of range
    vecs[4] = '{8'h8E, 8'h02, 2, {8'h00, 8'hC3, 8'h5A}, 5'b01111, 2};
    vecs[5] = '{8'h8E, 8'h0B, 0, {8'h00, 8'h00, 8'h00}, 5'b00001, 0};  // first invalid index
    vecs[6] = '{8'h8E, 8'h03, 0, {8'h00, 8'h00, 8'h00}, 5'b00011, 0};  // pointer only
    vecs[7] = '{8'h8E, 8'h0C, 1, {8'h00, 8'h00, 8'h55}, 5'b00001, 0};  // NACK keeps pointer

    rst_n = 1'b0; scl = 1'b1; sda_m = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    check("reset_sda_oe", sda_oe, 0);
    check("reset_busy", busy, 0);
    check("reset_wr_pulse", wr_pulse, 0);
    check("reset_wr_index", wr_index, 0);
    check("reset_regs_zero", (reg_data == '0), 1);
    rst_n = 1'b1;
    qwait();

    // Table-driven write transfers
    for (int i = 0; i < 8; i++) begin
      mask = 5'((1 << (2 + vecs[i].n)) - 1);
      model_write(vecs[i].addr, vecs[i].regb, vecs[i].n, vecs[i].d, macks);
      do_write(vecs[i].addr, vecs[i].regb, vecs[i].n, vecs[i].d,
               (vecs[i].exp_ack & mask) == mask, acks);
      check($sformatf("vec%0d_acks", i), acks & mask, vecs[i].exp_ack & mask);
      check_wr($sformatf("vec%0d", i), vecs[i].exp_wr);
    end
    check_regs("table");

    // Read at the retained pointer (3) after the out-of-range NACK
    bus_start();
    send_byte(8'h8F, a, an);
    check("ptr_read_addr_ack", a, 1);
    recv_byte(1'b0, b);
    check("ptr_read_byte", b, 8'hC3);
    m_ptr = (m_ptr + 1) % NR;
    bus_stop(0);

    // Set pointer, repeated START, read two bytes (ACK then NACK)
    bus_start();
    send_byte(8'h8E, a, an); check("rs_addr_w_ack", a, 1); check("rs_nr_addr_w_ack", an, 1);
    send_byte(8'h02, a, an); check("rs_reg_ack", a, 1);
    bus_start();
    send_byte(8'h8F, a, an); check("rs_addr_r_ack", a, 1); check("rs_nr_addr_r_nack", an, 0);
    recv_byte(1'b1, b); check("rs_byte0", b, 8'h5A);
    recv_byte(1'b0, b); check("rs_byte1", b, 8'hC3);
    check("rs_oe_after_nack", sda_oe, 0);
    m_ptr = 4;
    bus_stop(0);
    check_wr("rs", 0);

    // Randomised transfers against the model
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 2) != 2) begin
        logic [7:0]      addr, regb;
        logic [2:0][7:0] d;
        addr = ($urandom_range(0, 7) == 0) ? 8'h90 : 8'h8E;
        regb = 8'($urandom_range(0, 13));
        n    = $urandom_range(0, 3);
        d    = 24'($urandom());
        mask = 5'((1 << (2 + n)) - 1);
        model_write(addr, regb, n, d, macks);
        do_write(addr, regb, n, d, (macks & mask) == mask, acks);
        check($sformatf("rnd%0d_acks", t), acks & mask, macks & mask);
        check_wr($sformatf("rnd%0d", t), exp_wr.size());
      end else begin
        n = $urandom_range(1, 3);
        bus_start();
        send_byte(8'h8F, a, an);
        check($sformatf("rnd%0d_raddr_ack", t), a, 1);
        for (int i = 0; i < n; i++) begin
          recv_byte(i != n - 1, b);
          check($sformatf("rnd%0d_rbyte%0d", t, i), b, m_regs[m_ptr]);
          m_ptr = (m_ptr + 1) % NR;
        end
        bus_stop(0);
      end
    end
    check_regs("random");

    // Asynchronous reset while the target is ACKing a data byte
    bus_start();
    send_byte(8'h8E, a, an);
    send_byte(8'h03, a, an);
    for (int i = 7; i >= 0; i--) begin
      logic r, rn;
      clk_bit(i[0], r, rn);
    end
    sda_m = 1'b1; qwait();
    scl = 1'b1;   qwait();
    check("rst_oe_before", sda_oe, 1);
    rst_n = 1'b0;
    #1;
    check("rst_oe_async", sda_oe, 0);
    check("rst_regs_async", (reg_data == '0), 1);
    check("rst_busy_async", busy, 0);
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    qwait();
    scl = 1'b0; qwait();
    send_byte(8'h8E, a, an);
    check("rst_no_ack_without_start", a, 0);
    check("rst_busy_idle", busy, 0);
    bus_stop(0);
    begin
      logic [2:0][7:0] d;
      d = {8'h00, 8'h00, 8'h9C};
      model_write(8'h8E, 8'h05, 1, d, macks);
      do_write(8'h8E, 8'h05, 1, d, 1, acks);
      check("rst_fresh_acks", acks & 5'b00111, 5'b00111);
      check_wr("rst_fresh", 1);
    end
    check_regs("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
